// File: rtl/mux4_rr_arbiter_pkg.sv
// Shared types and helpers for the four-way round-robin arbiter.
// Holds the state encoding, requester count and one-hot grant helper.
package arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_t;

  localparam int N_REQ = 4;
  localparam int SEL_W = 2;

  function automatic logic [N_REQ-1:0] onehot4(input logic [SEL_W-1:0] idx);
    onehot4 = 4'b0001 << idx;
  endfunction

endpackage

// File: rtl/mux4_rr_arbiter_rr_pick4.sv
// Combinational round-robin winner search over four requesters.
// Search starts just after 'last' and ends on 'last' itself.
module rr_pick4
  import arb_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [SEL_W-1:0] last,
  output logic             valid,
  output logic [SEL_W-1:0] idx
);

  logic [SEL_W-1:0] cand;

  // NOTE: every variable written here gets a default first, so no latch is inferred.
  always_comb begin
    valid = 1'b0;
    idx   = last;
    cand  = last;
    for (int k = 1; k <= N_REQ; k++) begin
      cand = last + SEL_W'(k);
      if (!valid && req[cand]) begin
        valid = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter for a shared 4:1-muxed resource with a watchdog.
// Grant and mux select are registered together and held until release.
module mux4_rr_arbiter
  import arb_pkg::*;
#(
  parameter int TIMEOUT_W = 8,
  parameter int TIMEOUT   = 200
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  input  logic             done,
  output logic [N_REQ-1:0] gnt,
  output logic [SEL_W-1:0] sel,
  output logic             busy,
  output logic             timeout_err
);

  localparam logic [TIMEOUT_W-1:0] WD_LAST =
    TIMEOUT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  arb_state_t           state, state_nxt;
  logic [SEL_W-1:0]     last, last_nxt;
  logic [TIMEOUT_W-1:0] wd, wd_nxt;
  logic [N_REQ-1:0]     gnt_nxt;
  logic [SEL_W-1:0]     sel_nxt;
  logic                 busy_nxt;
  logic                 terr_nxt;

  logic [SEL_W-1:0]     pick_last;
  logic                 pick_valid;
  logic [SEL_W-1:0]     pick_idx;
  logic                 wd_expired;
  logic                 release_now;

  // While busy the owner is about to become 'last', so search from it directly.
  assign pick_last = (state == BUSY) ? sel : last;

  rr_pick4 u_pick (
    .req   (req),
    .last  (pick_last),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  assign wd_expired  = (TIMEOUT != 0) && (wd == WD_LAST);
  assign release_now = done || !req[sel] || wd_expired;

  always_comb begin
    state_nxt = state;
    last_nxt  = last;
    wd_nxt    = wd;
    gnt_nxt   = gnt;
    sel_nxt   = sel;
    busy_nxt  = busy;
    terr_nxt  = 1'b0;
    case (state)
      IDLE: begin
        if (pick_valid) begin
          state_nxt = BUSY;
          gnt_nxt   = onehot4(pick_idx);
          sel_nxt   = pick_idx;
          busy_nxt  = 1'b1;
          wd_nxt    = '0;
        end
      end
      BUSY: begin
        if (release_now) begin
          last_nxt = sel;
          // Completion and abort both take precedence over the watchdog.
          terr_nxt = !done && req[sel] && wd_expired;
          if (pick_valid) begin
            gnt_nxt = onehot4(pick_idx);
            sel_nxt = pick_idx;
            wd_nxt  = '0;
          end else begin
            state_nxt = IDLE;
            gnt_nxt   = '0;
            busy_nxt  = 1'b0;
          end
        end else if (wd != '1) begin
          wd_nxt = wd + 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      last        <= 2'd3;
      wd          <= '0;
      gnt         <= '0;
      sel         <= '0;
      busy        <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      state       <= state_nxt;
      last        <= last_nxt;
      wd          <= wd_nxt;
      gnt         <= gnt_nxt;
      sel         <= sel_nxt;
      busy        <= busy_nxt;
      timeout_err <= terr_nxt;
    end
  end

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Bench for mux4_rr_arbiter: vector table plus hand-written corner sequences.
// Two instances share stimulus; one uses TIMEOUT=5, the other TIMEOUT=4.
module tb_mux4_rr_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic       done;

  logic [3:0] gnt5, gnt4;
  logic [1:0] sel5, sel4;
  logic       busy5, busy4, terr5, terr4;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0] req;
    logic       done;
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       busy;
    logic       terr;
  } vec_t;

  typedef struct {
    logic [7:0] exp;
    bit         use4;
    string      name;
  } sb_t;

  vec_t vecs[$];
  sb_t  sbq[$];

  mux4_rr_arbiter #(.TIMEOUT_W(8), .TIMEOUT(5)) dut5 (
    .clk(clk), .rst(rst), .req(req), .done(done),
    .gnt(gnt5), .sel(sel5), .busy(busy5), .timeout_err(terr5)
  );

  mux4_rr_arbiter #(.TIMEOUT_W(8), .TIMEOUT(4)) dut4 (
    .clk(clk), .rst(rst), .req(req), .done(done),
    .gnt(gnt4), .sel(sel4), .busy(busy4), .timeout_err(terr4)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete in time");
    $fatal(1);
  end

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got gnt=%b sel=%0d busy=%b terr=%b, want gnt=%b sel=%0d busy=%b terr=%b",
               name, act[7:4], act[3:2], act[1], act[0], exp[7:4], exp[3:2], exp[1], exp[0]);
    end
  endtask

  function automatic logic [7:0] outs(input bit use4);
    return use4 ? {gnt4, sel4, busy4, terr4} : {gnt5, sel5, busy5, terr5};
  endfunction

  // Drive one cycle of stimulus, queue the expectation, compare after the edge.
  task automatic step(input string name, input bit use4, input logic [3:0] r, input logic d,
                      input logic [3:0] g, input logic [1:0] s, input logic b, input logic t);
    sb_t e;
    req  = r;
    done = d;
    sbq.push_back('{exp: {g, s, b, t}, use4: use4, name: name});
    @(posedge clk);
    #1;
    e = sbq.pop_front();
    check(e.name, outs(e.use4), e.exp);
  endtask

  function automatic void add(input logic [3:0] r, input logic d, input logic [3:0] g,
                              input logic [1:0] s, input logic b, input logic t);
    vecs.push_back('{req: r, done: d, gnt: g, sel: s, busy: b, terr: t});
  endfunction

  initial begin
    // Test 1: all requesting, done every third cycle -> 0,1,2,3,0 back-to-back.
    add(4'b1111, 0, 4'b0001, 0, 1, 0);
    for (int g = 0; g < 4; g++) begin
      add(4'b1111, 0, 4'b0001 << g, 2'(g), 1, 0);
      add(4'b1111, 0, 4'b0001 << g, 2'(g), 1, 0);
      add(4'b1111, 1, 4'b0001 << ((g + 1) % 4), 2'((g + 1) % 4), 1, 0);
    end
    add(4'b0000, 1, 4'b0000, 0, 0, 0);
    // Test 2: lone requester 2, done with req dropped, then done while idle.
    add(4'b0100, 0, 4'b0100, 2, 1, 0);
    add(4'b0100, 0, 4'b0100, 2, 1, 0);
    add(4'b0100, 0, 4'b0100, 2, 1, 0);
    add(4'b0000, 1, 4'b0000, 2, 0, 0);
    add(4'b0000, 1, 4'b0000, 2, 0, 0);
    // Test 3: watchdog (TIMEOUT=5) forces release, owner 1 re-granted.
    add(4'b0010, 0, 4'b0010, 1, 1, 0);
    for (int i = 0; i < 4; i++) add(4'b0010, 0, 4'b0010, 1, 1, 0);
    add(4'b0010, 0, 4'b0010, 1, 1, 1);
    add(4'b0010, 0, 4'b0010, 1, 1, 0);
    add(4'b0000, 0, 4'b0000, 1, 0, 0);
    // Test 4: owner 0 aborts, requester 3 granted on the same edge.
    add(4'b0001, 0, 4'b0001, 0, 1, 0);
    add(4'b1000, 0, 4'b1000, 3, 1, 0);
    add(4'b0000, 1, 4'b0000, 3, 0, 0);

    rst  = 1'b1;
    req  = 4'b0000;
    done = 1'b0;
    #1;
    check("reset_dut5", outs(0), 8'h00);
    check("reset_dut4", outs(1), 8'h00);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    step("post_reset_idle", 0, 4'b0000, 0, 4'b0000, 0, 0, 0);

    foreach (vecs[i]) begin
      step($sformatf("vec%0d", i), 0, vecs[i].req, vecs[i].done,
           vecs[i].gnt, vecs[i].sel, vecs[i].busy, vecs[i].terr);
    end

    // Test 5 (TIMEOUT=4): done on the expiry edge wins, no timeout_err.
    step("t5_grant", 1, 4'b0100, 0, 4'b0100, 2, 1, 0);
    step("t5_wd1",   1, 4'b0100, 0, 4'b0100, 2, 1, 0);
    step("t5_wd2",   1, 4'b0100, 0, 4'b0100, 2, 1, 0);
    step("t5_wd3",   1, 4'b0100, 0, 4'b0100, 2, 1, 0);
    step("t5_done_vs_timeout", 1, 4'b0100, 1, 4'b0100, 2, 1, 0);
    step("t5_abort_idle", 1, 4'b0000, 0, 4'b0000, 2, 0, 0);

    // Test 6: asynchronous reset mid-transfer, then requester 0 wins first.
    step("t6_grant", 0, 4'b0100, 0, 4'b0100, 2, 1, 0);
    step("t6_wd1",   0, 4'b0100, 0, 4'b0100, 2, 1, 0);
    step("t6_wd2",   0, 4'b0100, 0, 4'b0100, 2, 1, 0);
    step("t6_wd3",   0, 4'b0100, 0, 4'b0100, 2, 1, 0);
    #2;
    rst = 1'b1;
    #1;
    check("t6_async_clear_dut5", outs(0), 8'h00);
    check("t6_async_clear_dut4", outs(1), 8'h00);
    @(posedge clk);
    #1;
    check("t6_held_in_reset", outs(0), 8'h00);
    rst = 1'b0;
    step("t6_first_after_reset", 0, 4'b1111, 0, 4'b0001, 0, 1, 0);
    step("t6_second_after_reset", 0, 4'b1111, 1, 4'b0010, 1, 1, 0);
    step("t6_idle", 0, 4'b0000, 1, 4'b0000, 1, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mux4_rr_arbiter.md
Name: mux4_rr_arbiter

Overview:
- Round-robin arbiter that shares one 4:1-muxed resource (e.g. a shared memory/bus port) between four requesters.
- Grants exactly one requester at a time and drives the 2-bit mux select.
- Holds the grant until the resource signals completion.
- A watchdog counter recovers from a resource that never completes.
- Sits between the requesting units and the mux_4 select input.

Parameters:
- TIMEOUT_W, 8: width of the watchdog counter.
- TIMEOUT, 200: cycles in BUSY before forced release. 0 disables the watchdog. Must be < 2**TIMEOUT_W.

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  reset, asynchronous, active-high
- req  input  4  request vector, bit i = requester i
- done  input  1  resource completion pulse for the current transfer
- gnt  output  4  one-hot grant, all zeros when idle
- sel  output  2  mux select, equals index of the granted requester
- busy  output  1  high while a grant is outstanding
- timeout_err  output  1  one-cycle pulse when the watchdog forces a release

Behaviour:
- Reset is asynchronous and active-high. While rst=1 and on the cycle after:
  - gnt=0, sel=0, busy=0, timeout_err=0
  - state=IDLE, last pointer=3 (so requester 0 has first priority), watchdog=0.
- States: IDLE, BUSY.
- Priority:
  - Search order is last+1, last+2, last+3, last, modulo 4.
  - The first set req bit in that order wins.
  - This is a pure function of (req, last), implemented in the sub-module.
- IDLE:
  - If req != 0: next edge registers gnt=onehot(winner), sel=winner, busy=1, state=BUSY, watchdog=0. Grant latency is 1 cycle from req.
  - If req == 0: outputs unchanged (gnt=0, sel holds its previous value).
- BUSY: gnt, sel and owner stay constant. On each edge:
  - done=1: release. last=owner. If any req bit other than owner is set, re-arbitrate with the updated last and grant the new winner on the same edge (back-to-back, no idle cycle). If only the owner still requests, it is re-granted. If req=0, go to IDLE with gnt=0, busy=0.
  - done=0 and req[owner]=0 (requester aborted): release exactly as for done=1. timeout_err is not asserted.
  - done=0, req[owner]=1, TIMEOUT!=0 and watchdog==TIMEOUT-1: forced release as for done=1, and timeout_err=1 for exactly one cycle.
  - Otherwise: watchdog increments. The counter saturates and never wraps.
- Simultaneous done and timeout on the same edge: done wins and timeout_err stays 0.
- done while IDLE is ignored.
- Requests that arrive while BUSY wait. No requester waits more than 3 grants: fairness bound.
- sel is registered together with gnt, so the mux output is valid in the same cycle gnt is visible.
- Invariant: gnt is one-hot or zero at all times. busy == |gnt.
- Reset asserted mid-transfer: all outputs clear immediately (asynchronous). No completion is reported.

Decomposition:
- Shared package arb_pkg:
  - typedef enum logic {IDLE, BUSY} arb_state_t
  - localparam N_REQ=4
  - localparam SEL_W=2
  - helper function onehot4(logic [1:0])
- Sub-module rr_pick4: combinational; inputs req[3:0] and last[1:0]; outputs valid and idx[1:0].
- The top level holds the state register, last pointer, watchdog and output registers.

Test Plan:
1. After reset, req=4'b1111 -> next cycle gnt=0001, sel=0, busy=1. Pulse done every 3rd cycle -> grant sequence 0,1,2,3,0 with no idle cycle between grants.
2. req=4'b0100 only, done after 2 cycles, req then drops to 0 -> gnt=0100, sel=2 for 3 cycles, then gnt=0, busy=0, sel stays 2.
3. TIMEOUT=5, req=4'b0010 held, done never -> gnt=0010 for 5 cycles. timeout_err is high for 1 cycle at release. Requester 1 is then re-granted, since last=1 and no other req is set.
4. Owner 0 granted, req changes to 4'b1000 (owner drops) -> next edge gnt=1000, sel=3, timeout_err=0.
5. done and watchdog expiry on the same edge (TIMEOUT=4, done at cycle 4) -> release, timeout_err stays 0.
6. rst pulsed while gnt=0100 and watchdog=3 -> gnt=0, busy=0 asynchronously. After release with req=4'b1111, the first grant is to requester 0.
